// File: rtl/note_table_loader.sv
// Byte-serial loader for a small note table with N_CH registered playback read ports.
// Define NOTE_TABLE_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module note_table_loader #(
  parameter int N_BYTS     = 2,
  parameter int DEPTH      = 7,
  parameter int WIDTH_DATA = 10,
  parameter int N_CH       = 2
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic                       enable_l,
  input  logic                       load_start,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       play_start,
  input  logic                       play_stop,
  input  logic [N_CH*$clog2(DEPTH)-1:0] rd_addr,
  output logic                       byte_ready,
  output logic                       word_done,
  output logic                       full,
  output logic                       load_err,
  output logic [N_CH*WIDTH_DATA-1:0] out_data,
  output logic                       work
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (N_BYTS > 1) ? $clog2(N_BYTS) : 1;
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(N_BYTS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    COMMIT  = 3'd2,
    CHECK   = 3'd3,
    FULL    = 3'd4,
    PLAY    = 3'd5
  } state_t;

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic [AW-1:0]               wr_ptr_r;
  logic [BW-1:0]               byte_cnt_r;
  logic [WIDTH_DATA-1:0]       asm_r;
  logic [WIDTH_DATA-1:0]       mem_r [DEPTH];
  logic [N_CH*WIDTH_DATA-1:0]  out_data_r;
  logic                        en_s;
  logic                        byte_ready_s;
  logic                        accept_s;
  logic                        commit_s;
  logic                        restart_s;
  logic                        cksum_bad_s;
`ifdef NOTE_TABLE_CHECKSUM_EN
  logic [7:0]                  xor_r;
  logic                        load_err_r;
`endif

  assign en_s         = ~enable_l;
  assign byte_ready_s = en_s && ((state_r == COLLECT) || (state_r == CHECK));
  assign accept_s     = byte_ready_s && rx_valid;
  assign commit_s     = en_s && (state_r == COMMIT);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_l) state_r <= IDLE;
    else          state_r <= state_nxt_s;
  end

  // Next-state logic; restart_s marks any load_start that (re)opens a load
  always_comb begin
    state_nxt_s = state_r;
    restart_s   = 1'b0;
    cksum_bad_s = 1'b0;
    if (!en_s) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        IDLE, FULL, PLAY, COLLECT: begin
          if (load_start) begin
            state_nxt_s = COLLECT;
            restart_s   = 1'b1;
          end else if ((state_r == COLLECT) && accept_s && (byte_cnt_r == LAST_BYTE)) begin
            state_nxt_s = COMMIT;
          end else if ((state_r == FULL) && play_start) begin
            state_nxt_s = PLAY;
          end else if ((state_r == PLAY) && play_stop) begin
            state_nxt_s = FULL;
          end else begin
            state_nxt_s = state_r;
          end
        end
        COMMIT: begin
          if (wr_ptr_r < LAST_IDX) begin
            state_nxt_s = COLLECT;
          end else begin
`ifdef NOTE_TABLE_CHECKSUM_EN
            state_nxt_s = CHECK;
`else
            state_nxt_s = FULL;
`endif
          end
        end
        CHECK: begin
`ifdef NOTE_TABLE_CHECKSUM_EN
          if (accept_s) begin
            if (rx_data == xor_r) begin
              state_nxt_s = FULL;
            end else begin
              state_nxt_s = IDLE;
              cksum_bad_s = 1'b1;
            end
          end else begin
            state_nxt_s = CHECK;
          end
`else
          state_nxt_s = IDLE;
`endif
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Word assembly, pointers and running checksum
  always_ff @(posedge clk) begin
    if (!reset_l || restart_s) begin
      wr_ptr_r   <= '0;
      byte_cnt_r <= '0;
`ifdef NOTE_TABLE_CHECKSUM_EN
      xor_r      <= 8'h00;
`endif
    end else begin
      if (accept_s && (state_r == COLLECT)) begin
        for (int i = 0; i < WIDTH_DATA; i++) begin
          if ((i / 8) == int'(byte_cnt_r)) asm_r[i] <= rx_data[i % 8];
        end
        byte_cnt_r <= byte_cnt_r + 1'b1;
`ifdef NOTE_TABLE_CHECKSUM_EN
        xor_r      <= xor_r ^ rx_data;
`endif
      end
      if (commit_s) begin
        byte_cnt_r <= '0;
        if (wr_ptr_r < LAST_IDX) wr_ptr_r <= wr_ptr_r + 1'b1;
      end
    end
  end

`ifdef NOTE_TABLE_CHECKSUM_EN
  // Sticky checksum error, cleared only when a new load opens
  always_ff @(posedge clk) begin
    if (!reset_l || restart_s) load_err_r <= 1'b0;
    else if (cksum_bad_s)      load_err_r <= 1'b1;
  end
  assign load_err = load_err_r;
`else
  assign load_err = 1'b0;
`endif

  // Table storage: deliberately not reset so contents survive reset and reload
  always_ff @(posedge clk) begin
    if (commit_s) mem_r[wr_ptr_r] <= asm_r;
  end

  // Playback read ports; out-of-range indices read as zero
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      out_data_r <= '0;
    end else if (en_s) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if ((state_nxt_s == PLAY) && (int'(rd_addr[ch*AW +: AW]) < DEPTH))
          out_data_r[ch*WIDTH_DATA +: WIDTH_DATA] <= mem_r[rd_addr[ch*AW +: AW]];
        else
          out_data_r[ch*WIDTH_DATA +: WIDTH_DATA] <= '0;
      end
    end
  end

  assign byte_ready = byte_ready_s;
  assign word_done  = commit_s;
  assign full       = (state_r == FULL) || (state_r == PLAY);
  assign work       = en_s && (state_r == PLAY);
  assign out_data   = out_data_r;

endmodule

// File: tb/tb_note_table_loader.sv
// Randomized self-checking bench for note_table_loader against a word/byte-level table model.
module tb_note_table_loader;

  localparam int N_BYTS = 2;
  localparam int DEPTH  = 7;
  localparam int W      = 10;
  localparam int N_CH   = 2;
  localparam int AW     = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  logic enable_l = 1'b0;
  logic load_start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic play_start = 1'b0;
  logic play_stop = 1'b0;
  logic [N_CH*AW-1:0] rd_addr = '0;
  logic byte_ready, word_done, full, load_err, work;
  logic [N_CH*W-1:0] out_data;

  note_table_loader #(.N_BYTS(N_BYTS), .DEPTH(DEPTH), .WIDTH_DATA(W), .N_CH(N_CH)) dut (
    .clk(clk), .reset_l(reset_l), .enable_l(enable_l), .load_start(load_start),
    .rx_data(rx_data), .rx_valid(rx_valid), .play_start(play_start), .play_stop(play_stop),
    .rd_addr(rd_addr), .byte_ready(byte_ready), .word_done(word_done), .full(full),
    .load_err(load_err), .out_data(out_data), .work(work)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model of the table: what each entry should hold and how far the load has progressed
  logic [W-1:0] exp_mem [DEPTH];
  logic [7:0]   asm_b [N_BYTS];
  logic [7:0]   run_xor;
  int           byte_idx, word_idx, done_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N_CH*W-1:0] exp_out(input logic [N_CH*AW-1:0] ra);
    logic [N_CH*W-1:0] r;
    r = '0;
    for (int c = 0; c < N_CH; c++) begin
      int a;
      a = int'(ra[c*AW +: AW]);
      if (a < DEPTH) r[c*W +: W] = exp_mem[a];
    end
    return r;
  endfunction

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    byte_idx = 0; word_idx = 0; done_cnt = 0; run_xor = 8'h00;
    chk("load_ready", {31'd0, byte_ready}, 32'd1);
    chk("load_full", {31'd0, full}, 32'd0);
    chk("load_err_clr", {31'd0, load_err}, 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] d);
    int gap;
    logic [31:0] wv;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) tick();
    chk("byte_ready", {31'd0, byte_ready}, 32'd1);
    rx_data = d; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    asm_b[byte_idx] = d;
    run_xor = run_xor ^ d;
    byte_idx++;
    if (byte_idx == N_BYTS) begin
      chk("word_done", {31'd0, word_done}, 32'd1);
      chk("commit_not_ready", {31'd0, byte_ready}, 32'd0);
      if (word_done) done_cnt++;
      wv = 32'd0;
      for (int b = 0; b < N_BYTS; b++) wv[b*8 +: 8] = asm_b[b];
      exp_mem[word_idx] = wv[W-1:0];
      rx_valid = 1'($urandom_range(0, 1));
      rx_data = 8'($urandom);
      tick();
      rx_valid = 1'b0;
      chk("word_done_pulse", {31'd0, word_done}, 32'd0);
      byte_idx = 0;
      word_idx++;
    end else begin
      chk("word_done_mid", {31'd0, word_done}, 32'd0);
    end
  endtask

  task automatic push_random(input int n);
    for (int k = 0; k < n; k++) push_byte(8'($urandom));
  endtask

  task automatic finish_table(input bit good);
    chk("word_count", done_cnt, DEPTH);
`ifdef NOTE_TABLE_CHECKSUM_EN
    chk("check_ready", {31'd0, byte_ready}, 32'd1);
    chk("check_full", {31'd0, full}, 32'd0);
    rx_data = good ? run_xor : (run_xor ^ 8'h5A);
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("cksum_full", {31'd0, full}, good ? 32'd1 : 32'd0);
    chk("cksum_err", {31'd0, load_err}, good ? 32'd0 : 32'd1);
    chk("cksum_ready", {31'd0, byte_ready}, 32'd0);
`else
    chk("full", {31'd0, full}, 32'd1);
    chk("full_ready", {31'd0, byte_ready}, 32'd0);
    chk("no_err", {31'd0, load_err}, 32'd0);
`endif
  endtask

  task automatic enter_play(input logic [N_CH*AW-1:0] ra);
    rd_addr = ra;
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    chk("play_work", {31'd0, work}, 32'd1);
    chk("play_full", {31'd0, full}, 32'd1);
    chk("play_first", 32'(out_data), 32'(exp_out(ra)));
  endtask

  task automatic play_sweep(input int n);
    logic [N_CH*AW-1:0] ra;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < N_CH; c++)
        ra[c*AW +: AW] = (k < 8) ? AW'((k + c * 5) % 8) : AW'($urandom_range(0, 7));
      rd_addr = ra;
      tick();
      chk("play_read", 32'(out_data), 32'(exp_out(ra)));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    chk("rst_work", {31'd0, work}, 32'd0);
    chk("rst_wd", {31'd0, word_done}, 32'd0);
    chk("rst_out", 32'(out_data), 32'd0);
    reset_l = 1'b1;
    rx_valid = 1'b1; rx_data = 8'hFF;
    tick();
    rx_valid = 1'b0;
    chk("idle_ready", {31'd0, byte_ready}, 32'd0);

    // First load: word 0 = 0x12C from bytes 0x2C, 0x01
    start_load();
    push_byte(8'h2C);
    push_byte(8'h01);
    push_random(12);
    finish_table(1'b1);

    enter_play({3'd6, 3'd0});
    chk("mem0_12c", 32'(out_data[W-1:0]), 32'h12C);
    rd_addr = {3'd7, 3'd2};
    tick();
    chk("oob_read", 32'(out_data), 32'(exp_out({3'd7, 3'd2})));
    play_sweep(20);
    play_stop = 1'b1;
    tick();
    play_stop = 1'b0;
    chk("stop_work", {31'd0, work}, 32'd0);
    chk("stop_out", 32'(out_data), 32'd0);
    chk("stop_full", {31'd0, full}, 32'd1);

    // Restart after 3 bytes, then an enable hold mid-word
    start_load();
    push_random(3);
    start_load();
    push_random(2);
    push_random(1);
    for (int k = 0; k < 5; k++) begin
      enable_l = 1'b1;
      rx_valid = k[0] ? 1'b0 : 1'b1;
      rx_data = 8'($urandom);
      tick();
      chk("hold_ready", {31'd0, byte_ready}, 32'd0);
      chk("hold_wd", {31'd0, word_done}, 32'd0);
      chk("hold_work", {31'd0, work}, 32'd0);
      chk("hold_full", {31'd0, full}, 32'd0);
    end
    rx_valid = 1'b0;
    enable_l = 1'b0;
    #1;
    chk("resume_ready", {31'd0, byte_ready}, 32'd1);
    push_random(11);
    finish_table(1'b1);
    enter_play({3'd1, 3'd0});
    play_sweep(16);
    play_stop = 1'b1;
    tick();
    play_stop = 1'b0;

    // load_start beats play_start from FULL
    load_start = 1'b1; play_start = 1'b1;
    tick();
    load_start = 1'b0; play_start = 1'b0;
    chk("prio_ready", {31'd0, byte_ready}, 32'd1);
    chk("prio_work", {31'd0, work}, 32'd0);
    chk("prio_full", {31'd0, full}, 32'd0);
    byte_idx = 0; word_idx = 0; done_cnt = 0; run_xor = 8'h00;
    push_random(14);
    finish_table(1'b1);
    enter_play({3'd3, 3'd5});
    play_sweep(6);

    // Reset while playing
    reset_l = 1'b0;
    tick();
    reset_l = 1'b1;
    chk("rplay_work", {31'd0, work}, 32'd0);
    chk("rplay_out", 32'(out_data), 32'd0);
    chk("rplay_full", {31'd0, full}, 32'd0);
    chk("rplay_ready", {31'd0, byte_ready}, 32'd0);
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    chk("rplay_idle", {31'd0, work}, 32'd0);

    // Bad checksum (only meaningful with the checksum build)
    start_load();
    push_random(14);
`ifdef NOTE_TABLE_CHECKSUM_EN
    finish_table(1'b0);
    start_load();
    push_random(14);
    finish_table(1'b1);
`else
    finish_table(1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/note_table_loader.md
NOTE_TABLE_LOADER -- requirements
Module: note_table_loader

Interface
REQ-001 SHALL have parameter N_BYTS, default 2, meaning bytes per table word, 1..4.
REQ-002 SHALL have parameter DEPTH, default 7, meaning table entries, 2..64.
REQ-003 SHALL have parameter WIDTH_DATA, default 10, meaning stored word width; must be <= N_BYTS*8.
REQ-004 SHALL have parameter N_CH, default 2, meaning independent playback read channels, 1..4.
REQ-005 SHALL define AW = $clog2(DEPTH) as a derived localparam.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-007 SHALL have port reset_l, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port enable_l, input, 1 bit: active-low block enable.
REQ-009 SHALL have port load_start, input, 1 bit: request to (re)load the table.
REQ-010 SHALL have port rx_data, input, 8 bits: byte from the serial receiver.
REQ-011 SHALL have port rx_valid, input, 1 bit: rx_data is valid this cycle.
REQ-012 SHALL have port play_start, input, 1 bit: begin playback.
REQ-013 SHALL have port play_stop, input, 1 bit: end playback.
REQ-014 SHALL have port rd_addr, input, N_CH*AW bits: packed per-channel entry index, channel 0 in the LSBs.
REQ-015 SHALL have port byte_ready, output, 1 bit: a byte is accepted this cycle if rx_valid is high.
REQ-016 SHALL have port word_done, output, 1 bit: one-cycle pulse when a word is committed.
REQ-017 SHALL have port full, output, 1 bit: the table is completely loaded.
REQ-018 SHALL have port load_err, output, 1 bit: sticky checksum error flag.
REQ-019 SHALL have port out_data, output, N_CH*WIDTH_DATA bits: packed per-channel note value.
REQ-020 SHALL have port work, output, 1 bit: playback active.

Function
REQ-021 SHALL implement FSM states IDLE, COLLECT, COMMIT, CHECK, FULL, PLAY.
REQ-022 SHALL hold the FSM and all registers while enable_l=1, with byte_ready=0 and work=0.
REQ-023 SHALL go from IDLE to COLLECT on load_start, clearing wr_ptr, byte_cnt, the running XOR and load_err.
REQ-024 SHALL assert byte_ready only in COLLECT and CHECK; an rx_valid seen while byte_ready=0 is dropped.
REQ-025 SHALL, in COLLECT, write each accepted byte into assembly slot byte_cnt (first byte = LSBs) and increment byte_cnt.
REQ-026 SHALL go to COMMIT on the accept with byte_cnt=N_BYTS-1.
REQ-027 SHALL, in COMMIT (exactly one cycle), write assembly[WIDTH_DATA-1:0] to mem[wr_ptr], pulse word_done and reset byte_cnt.
REQ-028 SHALL leave COMMIT as follows: if wr_ptr<DEPTH-1, increment wr_ptr and go to COLLECT; else go to CHECK (macro defined) or FULL (macro undefined).
REQ-029 SHALL assert full=1 in FULL and PLAY only.
REQ-030 SHALL go from FULL to PLAY on play_start; load_start wins when both are asserted together and goes to COLLECT.
REQ-031 SHALL, in PLAY, hold work=1 and register out_data[ch] = mem[rd_addr[ch]] with 1-cycle latency.
REQ-032 SHALL return 0 for a channel whose rd_addr >= DEPTH.
REQ-033 SHALL leave PLAY on play_stop (to FULL) or on load_start (to COLLECT; load_start has priority).
REQ-034 SHALL drive out_data=0 outside PLAY.
REQ-035 SHALL accept load_start in COLLECT as a restart: wr_ptr and byte_cnt cleared, partial word discarded.
REQ-036 SHALL leave mem contents uncleared by reset and by reload until overwritten.

Reset
REQ-037 SHALL, with reset_l=0 at a clock edge, go to IDLE and clear wr_ptr, byte_cnt, XOR, byte_ready, word_done, full, load_err, work and out_data, mid-load or mid-play alike.

Configuration
REQ-038 SHALL include the checksum feature when NOTE_TABLE_CHECKSUM_EN is defined: CHECK accepts one byte; if it equals the XOR of all accepted data bytes, go to FULL, else set load_err=1 and go to IDLE.
REQ-039 SHALL, when NOTE_TABLE_CHECKSUM_EN is undefined, never enter CHECK and tie load_err to 0.

Verification
REQ-040 SHALL verify with defaults: load 14 bytes giving word 0 = {0x01,0x2C} -> mem[0]=0x12C, 7 word_done pulses, full=1.
REQ-041 SHALL verify PLAY with rd_addr ch0=0, ch1=6 -> next cycle out_data ch0=0x12C, ch1=mem[6]; rd_addr=7 on a channel -> that channel reads 0.
REQ-042 SHALL verify that load_start after 3 bytes restarts: the next 2 bytes commit to mem[0].
REQ-043 SHALL verify that enable_l=1 for 5 cycles mid-load with rx_valid pulsing -> no bytes accepted and state unchanged.
REQ-044 SHALL verify with the macro defined: correct XOR byte -> full=1; wrong byte -> load_err=1 and IDLE.
REQ-045 SHALL verify that reset_l=0 in PLAY -> next cycle work=0, out_data=0, full=0, state IDLE.
